data_port_arbiter: RTL and testbench
====================================

// Module: data_port_arbiter
// PURPOSE
// - Shares the single mm_ram data port between two OBI-style requesters:
//   M0 = core LSU, M1 = self-test pattern engine (active while start_test runs).
// - Sits between riscv_top data port and mm_ram data port inside the TB/test wrapper.
// - Round-robin arbitration; in-order response routing via an outstanding-ID FIFO.
// PARAMETERS
// - ADDR_WIDTH   32  data address width
// - DATA_WIDTH   32  read/write data width; BE width = DATA_WIDTH/8
// - MAX_OUTST    2   max granted-but-unanswered transactions (power of 2, >=1)
// PORTS
// - clk_i        in   1    clock
// - rst_i        in   1    synchronous reset, active-high
// - m{0,1}_req_i in   1    request (held stable until gnt)
// - m{0,1}_addr_i/we_i/be_i/wdata_i  in  ADDR_WIDTH/1/BE/DATA_WIDTH  request payload
// - m{0,1}_gnt_o    out 1  request accepted this cycle
// - m{0,1}_rvalid_o out 1  response valid
// - m{0,1}_rdata_o  out DATA_WIDTH  response data (s_rdata_i broadcast to both)
// - s_req_o/addr_o/we_o/be_o/wdata_o  out  request to mm_ram
// - s_gnt_i      in   1    mm_ram grant
// - s_rvalid_i   in   1    mm_ram response valid
// - s_rdata_i    in   DATA_WIDTH  mm_ram read data
// - busy_o       out  1    FIFO non-empty or any s_req_o
// - err_o        out  1    sticky: s_rvalid_i with empty FIFO
// BEHAVIOUR
// - Reset (rst_i=1 at posedge): FIFO empty, rr_ptr=M0, state=IDLE, err_o=0.
//   All outputs 0 during and after reset until a request arrives; outstanding
//   responses in flight at reset are discarded (rvalid_o stays 0).
// - FSM: IDLE -> HOLD when s_req_o=1 and s_gnt_i=0 (selection frozen to sel_q);
//   HOLD -> IDLE on s_gnt_i=1. In IDLE, sel = rr_ptr master if requesting, else
//   the other; no switch allowed in HOLD even if other master requests.
// - Issue gate: s_req_o = selected req & !fifo_full. Payload muxed combinationally
//   from selected master; 0 latency request path.
// - mX_gnt_o = s_gnt_i & s_req_o & (sel==X); only one gnt per cycle.
// - On grant: push sel into FIFO; rr_ptr <= ~sel (loser gets priority next).
// - Response: s_rvalid_i pops FIFO head; mX_rvalid_o = s_rvalid_i & head==X,
//   same cycle (0 added latency). rdata broadcast.
// - Push and pop same cycle: both take effect, count unchanged. When full,
//   issue blocked even if a pop occurs that cycle (no bypass).
// - s_rvalid_i with FIFO empty: no rvalid_o, err_o<=1 (cleared only by reset).
// - Count width $clog2(MAX_OUTST+1); read/write pointers wrap modulo MAX_OUTST.
// - Single requester: back-to-back grants every cycle allowed while FIFO not full.
// STRUCTURE
// - Package data_arb_pkg: typedef logic [0:0] mst_id_t; localparams MST_CORE=0,
//   MST_TEST=1; typedef enum {ARB_IDLE, ARB_HOLD} arb_state_e.
// - Sub-module arb_id_fifo (DEPTH=MAX_OUTST, type mst_id_t, push/pop/full/empty,
//   sync active-high reset). Arbiter FSM + muxes in data_port_arbiter.
// TESTING
// - Reset: drive reqs high with rst_i=1 -> all gnt/rvalid/s_req_o=0, err_o=0.
// - M0 only, 4 reads addr 0x100..0x10C, s_gnt_i=1, rvalid 1 cycle later ->
//   4 m0_gnt_o, 4 m0_rvalid_o in order, m1 outputs stay 0.
// - Both req every cycle, s_gnt_i=1 -> grants alternate M0,M1,M0,M1; rvalid
//   routed per FIFO order with matching rdata 0xA0,0xB1,0xA2,0xB3.
// - M0 req, s_gnt_i=0 for 3 cycles while M1 raises req -> s_addr_o stays M0 addr,
//   no m1_gnt_o; grant on cycle 4 goes to M0, M1 granted next.
// - MAX_OUTST=2, s_rvalid_i withheld -> 2 grants then s_req_o=0; one rvalid
//   reopens issue next cycle; rst_i mid-flight -> late rvalid dropped, err_o=1.

Source files
------------

// File: rtl/data_arb_pkg.sv
// Shared types for the data-port arbiter slice.
// - mst_id_t     : requester identifier (one bit, two requesters)
// - MST_CORE     : core LSU requester
// - MST_TEST     : self-test pattern engine requester
// - arb_state_e  : arbiter FSM states
package data_arb_pkg;

    typedef logic [0:0] mst_id_t;

    localparam mst_id_t MST_CORE = 1'b0;
    localparam mst_id_t MST_TEST = 1'b1;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_e;

endpackage

// File: rtl/arb_id_fifo.sv
// Outstanding-ID FIFO: records which requester owns each granted but not yet
// answered transaction, so responses can be routed in issue order.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   push_i, data_i    write an ID (ignored when full)
//   pop_i             drop the head entry (ignored when empty)
//   data_o            head entry
//   full_o, empty_o   occupancy flags
module arb_id_fifo
    import data_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter type         T     = mst_id_t
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  T     data_i,
    input  logic pop_i,
    output T     data_o,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T                 mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    // Explicit wrap so non-power-of-two depths also work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign data_o  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push_i & ~full_o;
        do_pop   = pop_i & ~empty_o;
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
            end
        end
    end

endmodule

// File: rtl/data_port_arbiter.sv
// Shares one OBI-style mm_ram data port between the core LSU (M0) and the
// self-test pattern engine (M1). Round-robin selection, selection frozen
// while a request waits for grant, in-order response routing via an ID FIFO.
// Ports:
//   clk_i, rst_i                         clock, synchronous active-high reset
//   mX_req_i/addr_i/we_i/be_i/wdata_i    requester X request + payload
//   mX_gnt_o, mX_rvalid_o, mX_rdata_o    requester X grant / response
//   s_req_o/addr_o/we_o/be_o/wdata_o     request to mm_ram
//   s_gnt_i, s_rvalid_i, s_rdata_i       mm_ram grant / response
//   busy_o                               transactions outstanding or issuing
//   err_o                                sticky: response with nothing outstanding
module data_port_arbiter
    import data_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_OUTST  = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    m0_req_i,
    input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
    input  logic                    m0_we_i,
    input  logic [DATA_WIDTH/8-1:0] m0_be_i,
    input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
    output logic                    m0_gnt_o,
    output logic                    m0_rvalid_o,
    output logic [DATA_WIDTH-1:0]   m0_rdata_o,
    input  logic                    m1_req_i,
    input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
    input  logic                    m1_we_i,
    input  logic [DATA_WIDTH/8-1:0] m1_be_i,
    input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
    output logic                    m1_gnt_o,
    output logic                    m1_rvalid_o,
    output logic [DATA_WIDTH-1:0]   m1_rdata_o,
    output logic                    s_req_o,
    output logic [ADDR_WIDTH-1:0]   s_addr_o,
    output logic                    s_we_o,
    output logic [DATA_WIDTH/8-1:0] s_be_o,
    output logic [DATA_WIDTH-1:0]   s_wdata_o,
    input  logic                    s_gnt_i,
    input  logic                    s_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   s_rdata_i,
    output logic                    busy_o,
    output logic                    err_o
);

    arb_state_e state_q, state_d;
    mst_id_t    sel_q, sel_d;
    mst_id_t    rr_q, rr_d;
    mst_id_t    sel;
    mst_id_t    head_id;
    logic       err_q, err_d;
    logic [1:0] req;
    logic       issue, grant, pop;
    logic       fifo_full, fifo_empty;

    assign req = {m1_req_i, m0_req_i};

    arb_id_fifo #(
        .DEPTH (MAX_OUTST),
        .T     (mst_id_t)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (grant),
        .data_i  (sel),
        .pop_i   (pop),
        .data_o  (head_id),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        sel     = sel_q;
        rr_d    = rr_q;
        err_d   = err_q;

        if (state_q == ARB_IDLE) begin
            sel = req[rr_q] ? rr_q : ~rr_q;
        end

        // Reset gating keeps every output quiet in the reset cycle itself,
        // even though the registers only clear at the edge.
        issue = req[sel] & ~fifo_full & ~rst_i;
        grant = issue & s_gnt_i;
        pop   = s_rvalid_i & ~fifo_empty & ~rst_i;

        case (state_q)
            ARB_IDLE: begin
                if (issue && !s_gnt_i) begin
                    state_d = ARB_HOLD;
                    sel_d   = sel;
                end
            end
            ARB_HOLD: begin
                if (s_gnt_i) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        if (grant) begin
            rr_d = ~sel;
        end
        if (s_rvalid_i && fifo_empty) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ARB_IDLE;
            sel_q   <= MST_CORE;
            rr_q    <= MST_CORE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            rr_q    <= rr_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        s_req_o   = issue;
        s_addr_o  = '0;
        s_we_o    = 1'b0;
        s_be_o    = '0;
        s_wdata_o = '0;
        if (issue) begin
            if (sel == MST_TEST) begin
                s_addr_o  = m1_addr_i;
                s_we_o    = m1_we_i;
                s_be_o    = m1_be_i;
                s_wdata_o = m1_wdata_i;
            end else begin
                s_addr_o  = m0_addr_i;
                s_we_o    = m0_we_i;
                s_be_o    = m0_be_i;
                s_wdata_o = m0_wdata_i;
            end
        end
    end

    assign m0_gnt_o    = grant & (sel == MST_CORE);
    assign m1_gnt_o    = grant & (sel == MST_TEST);
    assign m0_rvalid_o = pop & (head_id == MST_CORE);
    assign m1_rvalid_o = pop & (head_id == MST_TEST);
    assign m0_rdata_o  = s_rdata_i;
    assign m1_rdata_o  = s_rdata_i;
    assign busy_o      = (~fifo_empty | issue) & ~rst_i;
    assign err_o       = err_q;

endmodule

// File: tb/tb_data_port_arbiter.sv
module tb_data_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        m0_req_i, m1_req_i;
    logic [31:0] m0_addr_i, m1_addr_i;
    logic        m0_we_i, m1_we_i;
    logic [3:0]  m0_be_i, m1_be_i;
    logic [31:0] m0_wdata_i, m1_wdata_i;
    logic        m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic        s_req_o, s_we_o;
    logic [31:0] s_addr_o, s_wdata_o;
    logic [3:0]  s_be_o;
    logic        s_gnt_i, s_rvalid_i;
    logic [31:0] s_rdata_i;
    logic        busy_o, err_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_port_arbiter #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .MAX_OUTST  (2)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .m0_req_i    (m0_req_i),
        .m0_addr_i   (m0_addr_i),
        .m0_we_i     (m0_we_i),
        .m0_be_i     (m0_be_i),
        .m0_wdata_i  (m0_wdata_i),
        .m0_gnt_o    (m0_gnt_o),
        .m0_rvalid_o (m0_rvalid_o),
        .m0_rdata_o  (m0_rdata_o),
        .m1_req_i    (m1_req_i),
        .m1_addr_i   (m1_addr_i),
        .m1_we_i     (m1_we_i),
        .m1_be_i     (m1_be_i),
        .m1_wdata_i  (m1_wdata_i),
        .m1_gnt_o    (m1_gnt_o),
        .m1_rvalid_o (m1_rvalid_o),
        .m1_rdata_o  (m1_rdata_o),
        .s_req_o     (s_req_o),
        .s_addr_o    (s_addr_o),
        .s_we_o      (s_we_o),
        .s_be_o      (s_be_o),
        .s_wdata_o   (s_wdata_o),
        .s_gnt_i     (s_gnt_i),
        .s_rvalid_i  (s_rvalid_i),
        .s_rdata_i   (s_rdata_i),
        .busy_o      (busy_o),
        .err_o       (err_o)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Apply one cycle of stimulus at the falling edge, then let combinational
    // outputs settle before the caller checks them.
    task automatic drive(input logic rst, input logic r0, input logic r1,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic g, input logic v, input logic [31:0] rd);
        @(negedge clk);
        rst_i      = rst;
        m0_req_i   = r0;
        m1_req_i   = r1;
        m0_addr_i  = a0;
        m1_addr_i  = a1;
        s_gnt_i    = g;
        s_rvalid_i = v;
        s_rdata_i  = rd;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        exp_m;
        int          j;

        rst_i = 1'b1;
        m0_we_i = 1'b0;  m0_be_i = 4'hF; m0_wdata_i = 32'h0;
        m1_we_i = 1'b1;  m1_be_i = 4'h3; m1_wdata_i = 32'hCAFE0001;
        m0_req_i = 1'b0; m1_req_i = 1'b0; m0_addr_i = '0; m1_addr_i = '0;
        s_gnt_i = 1'b0;  s_rvalid_i = 1'b0; s_rdata_i = '0;

        // Reset with both requesting and the slave granting / answering.
        for (int c = 0; c < 2; c++) begin
            drive(1, 1, 1, 32'h100, 32'h300, 1, 1, 32'h55);
            check_eq("rst_s_req", s_req_o, 0);
            check_eq("rst_gnt", {m0_gnt_o, m1_gnt_o}, 0);
            check_eq("rst_rvalid", {m0_rvalid_o, m1_rvalid_o}, 0);
            check_eq("rst_busy", busy_o, 0);
        end
        check_eq("rst_err", err_o, 0);

        // M0 alone: four reads, response one cycle after each grant.
        for (int k = 0; k < 4; k++) begin
            drive(0, 1, 0, 32'h100 + 32'(4 * k), 32'h0, 1, k >= 1, 32'h1000 + 32'(k));
            check_eq("m0_gnt", m0_gnt_o, 1);
            check_eq("m0_addr", s_addr_o, 32'h100 + 32'(4 * k));
            check_eq("m0_be", s_be_o, 4'hF);
            check_eq("m1_quiet", {m1_gnt_o, m1_rvalid_o}, 0);
            check_eq("m0_rvalid", m0_rvalid_o, k >= 1);
        end
        drive(0, 0, 0, 0, 0, 0, 1, 32'h1003);
        check_eq("m0_last_rvalid", m0_rvalid_o, 1);
        check_eq("m0_last_rdata", m0_rdata_o, 32'h1003);
        check_eq("m0_busy_tail", busy_o, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check_eq("idle_busy", busy_o, 0);
        check_eq("idle_err", err_o, 0);

        // Return round-robin pointer to M0, then both request every cycle.
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            j  = k - 1;
            rd = (j % 2 == 0) ? (32'hA0 + 32'(j)) : (32'hB0 + 32'(j));
            drive(0, k < 4, k < 4, 32'h200, 32'h300, k < 4, k >= 1, rd);
            if (k < 4) begin
                exp_m = k[0];
                check_eq("alt_m0_gnt", m0_gnt_o, !exp_m);
                check_eq("alt_m1_gnt", m1_gnt_o, exp_m);
                check_eq("alt_addr", s_addr_o, exp_m ? 32'h300 : 32'h200);
                check_eq("alt_we", s_we_o, exp_m);
            end
            if (k >= 1) begin
                check_eq("alt_m0_rvalid", m0_rvalid_o, j % 2 == 0);
                check_eq("alt_m1_rvalid", m1_rvalid_o, j % 2 == 1);
                check_eq("alt_rdata", (j % 2 == 0) ? m0_rdata_o : m1_rdata_o, rd);
            end
        end

        // Selection frozen while the slave stalls; M1 waits its turn.
        drive(0, 1, 0, 32'h400, 32'h500, 0, 0, 0);
        check_eq("hold_req", s_req_o, 1);
        check_eq("hold_addr0", s_addr_o, 32'h400);
        for (int k = 0; k < 2; k++) begin
            drive(0, 1, 1, 32'h400, 32'h500, 0, 0, 0);
            check_eq("hold_addr", s_addr_o, 32'h400);
            check_eq("hold_no_gnt", {m0_gnt_o, m1_gnt_o}, 0);
        end
        drive(0, 1, 1, 32'h400, 32'h500, 1, 0, 0);
        check_eq("hold_m0_gnt", {m1_gnt_o, m0_gnt_o}, 2'b01);
        check_eq("hold_gnt_addr", s_addr_o, 32'h400);
        drive(0, 0, 1, 32'h400, 32'h500, 1, 0, 0);
        check_eq("hold_m1_gnt", {m1_gnt_o, m0_gnt_o}, 2'b10);
        check_eq("hold_m1_addr", s_addr_o, 32'h500);
        drive(0, 0, 0, 0, 0, 0, 1, 32'h44);
        check_eq("hold_rv0", {m1_rvalid_o, m0_rvalid_o}, 2'b01);
        drive(0, 0, 0, 0, 0, 0, 1, 32'h55);
        check_eq("hold_rv1", {m1_rvalid_o, m0_rvalid_o}, 2'b10);

        // Outstanding limit of two, no bypass on pop, reset mid-flight.
        drive(0, 1, 0, 32'h600, 0, 1, 0, 0);
        check_eq("full_g0", m0_gnt_o, 1);
        drive(0, 1, 0, 32'h600, 0, 1, 0, 0);
        check_eq("full_g1", m0_gnt_o, 1);
        drive(0, 1, 0, 32'h600, 0, 1, 0, 0);
        check_eq("full_block", {s_req_o, m0_gnt_o}, 0);
        check_eq("full_busy", busy_o, 1);
        drive(0, 1, 0, 32'h600, 0, 1, 1, 32'h77);
        check_eq("full_pop_rv", m0_rvalid_o, 1);
        check_eq("full_no_bypass", s_req_o, 0);
        drive(0, 1, 0, 32'h600, 0, 1, 0, 0);
        check_eq("full_reopen", m0_gnt_o, 1);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        check_eq("mid_rst_busy", busy_o, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 32'h88);
        check_eq("late_rv_drop", {m1_rvalid_o, m0_rvalid_o}, 0);
        check_eq("late_err_pre", err_o, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check_eq("late_err", err_o, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check_eq("err_sticky", err_o, 1);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check_eq("err_cleared", err_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
